uart_tx_top: RTL and testbench

UART_TX_TOP -- requirements
Module: uart_tx_top

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/uart_tx_serializer.sv | 44 ++++
 rtl/uart_tx_top.sv | 123 ++++++++++++
 tb/tb_uart_tx_top.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter.
// Contents:
//   tx_state_t : FSM state encoding
//   SEL_*      : output-mux select codes decoded from the state
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [2:0] SEL_START  = 3'd0;
    localparam logic [2:0] SEL_STOP   = 3'd1;
    localparam logic [2:0] SEL_DATA   = 3'd2;
    localparam logic [2:0] SEL_PARITY = 3'd3;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload latch and data-bit index counter for the UART transmitter.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   i_load, i_data : latch payload on frame acceptance
//   i_advance      : step the bit index (otherwise it returns to 0)
//   o_bit_next     : payload bit selected by the next-cycle index
//   o_done         : index is at the last payload bit
//   o_data_xor     : XOR reduction of the latched payload
module uart_tx_serializer #(
    parameter int dataWidth    = 8,
    parameter int counterWidth = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_advance,
    input  logic [dataWidth-1:0] i_data,
    output logic                 o_bit_next,
    output logic                 o_done,
    output logic                 o_data_xor
);

    logic [dataWidth-1:0]    r_data;
    logic [counterWidth-1:0] r_cnt;
    logic [counterWidth-1:0] w_cnt_next;

    assign w_cnt_next = i_advance ? r_cnt + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_load) r_data <= i_data;
            r_cnt <= w_cnt_next;
        end
    end

    // The top registers tx_out, so it needs the bit for the coming cycle.
    assign o_bit_next = r_data[w_cnt_next];
    assign o_done     = (r_cnt == counterWidth'(dataWidth - 1));
    assign o_data_xor = ^r_data;

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter, one bit per clock: start, payload LSB first,
// optional parity, stop.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   p_data     : payload, sampled when a request is accepted
//   data_valid : one-cycle send request (honoured only in IDLE)
//   par_en     : insert parity bit (sampled on acceptance)
//   par_type   : 0 even, 1 odd parity (sampled on acceptance)
//   tx_out     : registered serial line, idle high
//   busy       : registered, high while a frame is on tx_out
//
// state  | meaning
// IDLE   | line high, waiting for data_valid
// START  | start bit (0)
// DATA   | payload bits, LSB first
// PARITY | parity bit (only when parity enabled)
// STOP   | stop bit (1), then back to IDLE
module uart_tx_top
    import uart_tx_pkg::*;
#(
    parameter int dataWidth    = 8,
    parameter int counterWidth = 3,
    parameter int muxSelWidth  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [dataWidth-1:0] p_data,
    input  logic                 data_valid,
    input  logic                 par_en,
    input  logic                 par_type,
    output logic                 tx_out,
    output logic                 busy
);

    tx_state_t              r_state;
    tx_state_t              w_next_state;
    logic                   r_par_en;
    logic                   r_par_type;
    logic                   r_tx_out;
    logic                   r_busy;
    logic                   w_accept;
    logic                   w_advance;
    logic                   w_bit_next;
    logic                   w_done;
    logic                   w_data_xor;
    logic                   w_parity;
    logic [muxSelWidth-1:0] w_sel;
    logic                   w_tx_next;

    assign w_accept  = (r_state == ST_IDLE) && data_valid;
    assign w_advance = (r_state == ST_DATA) && !w_done;
    assign w_parity  = w_data_xor ^ r_par_type;

    uart_tx_serializer #(
        .dataWidth    (dataWidth),
        .counterWidth (counterWidth)
    ) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_advance  (w_advance),
        .i_data     (p_data),
        .o_bit_next (w_bit_next),
        .o_done     (w_done),
        .o_data_xor (w_data_xor)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_tx_out   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_tx_out <= w_tx_next;
            r_busy   <= (w_next_state != ST_IDLE);
            if (w_accept) begin
                r_par_en   <= par_en;
                r_par_type <= par_type;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (data_valid) w_next_state = ST_START;
            ST_START:  w_next_state = ST_DATA;
            ST_DATA:   if (w_done) w_next_state = r_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: w_next_state = ST_STOP;
            ST_STOP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Select is decoded from the next state so the output register
    // presents each bit in the same cycle the state register enters it.
    always_comb begin
        w_sel = muxSelWidth'(SEL_STOP);
        case (w_next_state)
            ST_START:  w_sel = muxSelWidth'(SEL_START);
            ST_DATA:   w_sel = muxSelWidth'(SEL_DATA);
            ST_PARITY: w_sel = muxSelWidth'(SEL_PARITY);
            default:   w_sel = muxSelWidth'(SEL_STOP);
        endcase
    end

    always_comb begin
        w_tx_next = 1'b1;
        case (w_sel)
            muxSelWidth'(SEL_START):  w_tx_next = 1'b0;
            muxSelWidth'(SEL_DATA):   w_tx_next = w_bit_next;
            muxSelWidth'(SEL_PARITY): w_tx_next = w_parity;
            default:                  w_tx_next = 1'b1;
        endcase
    end

    assign tx_out = r_tx_out;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_top.sv
module tb_uart_tx_top;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_type;
    logic       tx_out;
    logic       busy;

    int n_chk;
    int n_pass;

    uart_tx_top dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_type   (par_type),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic obs, input logic exp, input string tag);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Frame bits are indexed in transmission order: index 0 is the start bit.
    function automatic logic [0:10] mk_frame(input logic [7:0] d, input logic pe, input logic pt);
        logic [0:10] f;
        f = '1;
        f[0] = 1'b0;
        for (int j = 0; j < 8; j++) f[1+j] = d[j];
        if (pe) f[9] = (^d) ^ pt;
        return f;
    endfunction

    task automatic pulse(input logic [7:0] d, input logic pe, input logic pt);
        @(negedge clk);
        p_data = d; par_en = pe; par_type = pt; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    // Starts sampling in the start-bit cycle. inject_at >= 0 raises a
    // conflicting request during that bit cycle.
    task automatic run_frame(input logic [0:10] exp, input int nbits, input int inject_at, input string tag);
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) @(negedge clk);
            if (i == inject_at + 1) data_valid = 1'b0;
            chk(tx_out, exp[i], $sformatf("%s tx bit%0d", tag, i));
            chk(busy, 1'b1, $sformatf("%s busy bit%0d", tag, i));
            if (i == inject_at) begin
                data_valid = 1'b1; p_data = 8'hFF; par_en = 1'b0; par_type = ~par_type;
            end
        end
        @(negedge clk);
        data_valid = 1'b0;
        chk(tx_out, 1'b1, $sformatf("%s tx after", tag));
        chk(busy, 1'b0, $sformatf("%s busy after", tag));
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tx_out, 1'b1, $sformatf("%s tx idle%0d", tag, i));
            chk(busy, 1'b0, $sformatf("%s busy idle%0d", tag, i));
        end
    endtask

    initial begin
        logic [7:0]  d;
        logic        pe;
        logic        pt;
        logic [0:10] f;
        n_chk = 0; n_pass = 0;
        rst = 1'b0; p_data = 8'h00; data_valid = 1'b0; par_en = 1'b0; par_type = 1'b0;

        // reset and idle
        @(negedge clk);
        chk(tx_out, 1'b1, "in reset tx");
        chk(busy, 1'b0, "in reset busy");
        @(negedge clk);
        rst = 1'b1;
        idle_check(3, "post reset");

        // 0xA5 even parity: 0 10100101 0 1
        pulse(8'hA5, 1'b1, 1'b0);
        run_frame(11'b0_10100101_0_1, 11, -1, "A5 even");

        // 0x01 odd parity: parity 0
        pulse(8'h01, 1'b1, 1'b1);
        run_frame(11'b0_10000000_0_1, 11, -1, "01 odd");

        // 0x01 even parity: parity 1
        pulse(8'h01, 1'b1, 1'b0);
        run_frame(11'b0_10000000_1_1, 11, -1, "01 even");

        // 0x00 no parity: 10-bit frame
        pulse(8'h00, 1'b0, 1'b0);
        run_frame(11'b0_00000000_1_1, 10, -1, "00 nopar");

        // 0x3C with 0xFF request mid-frame: 0 00111100 0 1
        pulse(8'h3C, 1'b1, 1'b0);
        run_frame(11'b0_00111100_0_1, 11, 4, "3C midreq");
        idle_check(12, "3C no second");

        // request during stop bit is dropped
        pulse(8'h3C, 1'b1, 1'b0);
        run_frame(11'b0_00111100_0_1, 11, 10, "3C stopreq");
        idle_check(12, "stopreq no second");

        // ten sends, each after busy falls
        for (int i = 0; i < 10; i++) begin
            d  = 8'(i * 37 + 5);
            pe = (i % 3) != 0;
            pt = i[0];
            f  = mk_frame(d, pe, pt);
            pulse(d, pe, pt);
            run_frame(f, pe ? 11 : 10, -1, $sformatf("b2b%0d", i));
        end

        // reset during DATA
        pulse(8'h96, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk(tx_out, 1'b1, "mid reset tx");
        chk(busy, 1'b0, "mid reset busy");
        @(negedge clk);
        chk(tx_out, 1'b1, "mid reset hold tx");
        chk(busy, 1'b0, "mid reset hold busy");
        rst = 1'b1;
        idle_check(3, "after abort");

        // 0x5A even parity: 0 01011010 0 1
        pulse(8'h5A, 1'b1, 1'b0);
        run_frame(11'b0_01011010_0_1, 11, -1, "5A after rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
